// File: rtl/bridge_pkg.sv
// Shared definitions for the SRAM-like bus bridge: access size encodings and
// the width helper used for occupancy counters.
package bridge_pkg;

   typedef enum logic [1:0] {
      SZ_BYTE = 2'd0,
      SZ_HALF = 2'd1,
      SZ_WORD = 2'd2
   } size_e;

   // Bits needed to hold any value 0..max_val inclusive.
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/resp_fifo.sv
// Small synchronous FIFO with registered storage and a synchronous clear.
// pop_data always shows the head entry; the caller gates it with count.
module resp_fifo
   import bridge_pkg::*;
#(
   parameter int WIDTH = 33,
   parameter int DEPTH = 2
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        clear,
   input  logic                        push,
   input  logic [WIDTH-1:0]            push_data,
   input  logic                        pop,
   output logic [WIDTH-1:0]            pop_data,
   output logic [cnt_width(DEPTH)-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = cnt_width(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
      return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
   endfunction

   assign do_push  = push && (count != CNT_W'(DEPTH));
   assign do_pop   = pop && (count != '0);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
      end else if (clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= ptr_inc(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/sram_like_bridge.sv
// Bridge from a pipeline memory request port to an SRAM-like split-transaction
// bus, with bounded outstanding requests, a response FIFO and flush-cancel.
module sram_like_bridge
   import bridge_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int MAX_OUT = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_wr,
   input  logic [1:0]          req_size,
   input  logic [DATA_W/8-1:0] req_wstrb,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
   output logic                resp_valid,
   input  logic                resp_ready,
   output logic [DATA_W-1:0]   resp_rdata,
   output logic                resp_wr,
   input  logic                flush,
   output logic                bus_req,
   output logic                bus_wr,
   output logic [1:0]          bus_size,
   output logic [DATA_W/8-1:0] bus_wstrb,
   output logic [ADDR_W-1:0]   bus_addr,
   output logic [DATA_W-1:0]   bus_wdata,
   input  logic                bus_addr_ok,
   input  logic                bus_data_ok,
   input  logic [DATA_W-1:0]   bus_rdata
);

   localparam int CNT_W = cnt_width(MAX_OUT);

   logic [CNT_W-1:0] inflight;
   logic [CNT_W-1:0] inflight_nxt;
   logic [CNT_W-1:0] cancel_cnt;
   logic [CNT_W-1:0] cancel_nxt;
   logic [CNT_W-1:0] fifo_cnt;
   logic [CNT_W-1:0] tag_cnt;
   logic             credit;
   logic             accept;
   logic             ack;
   logic             resp_push;
   logic             resp_pop;
   logic             tag_head;
   logic [DATA_W:0]  resp_head;

   // Buffered responses hold credit too, so the FIFO can never overflow.
   assign credit = ({1'b0, inflight} + {1'b0, fifo_cnt}) < (CNT_W + 1)'(MAX_OUT);

   assign bus_req   = req_valid & credit & ~flush & ~reset;
   assign bus_wr    = req_wr;
   assign bus_size  = req_size;
   assign bus_wstrb = req_wstrb;
   assign bus_addr  = req_addr;
   assign bus_wdata = req_wdata;

   assign req_ready = bus_req & bus_addr_ok;
   assign accept    = req_ready;

   // A stray data_ok with nothing outstanding is ignored so counters stay at 0.
   assign ack       = bus_data_ok & (inflight != '0);
   assign resp_push = ack & (cancel_cnt == '0);

   assign resp_valid = (fifo_cnt != '0) & ~flush;
   assign resp_pop   = resp_valid & resp_ready;
   assign resp_rdata = resp_head[DATA_W-1:0];
   assign resp_wr    = resp_head[DATA_W];

   always_comb begin
      inflight_nxt = inflight;
      if (accept && !ack) begin
         inflight_nxt = inflight + 1'b1;
      end else if (!accept && ack) begin
         inflight_nxt = inflight - 1'b1;
      end

      cancel_nxt = cancel_cnt;
      if (flush) begin
         cancel_nxt = inflight_nxt;
      end else if (ack && (cancel_cnt != '0)) begin
         cancel_nxt = cancel_cnt - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inflight   <= '0;
         cancel_cnt <= '0;
      end else begin
         inflight   <= inflight_nxt;
         cancel_cnt <= cancel_nxt;
      end
   end

   // Tag queue tracks every outstanding transaction, including cancelled ones,
   // so it is never cleared by flush.
   resp_fifo #(
      .WIDTH (1),
      .DEPTH (MAX_OUT)
   ) u_tag_q (
      .clk       (clk),
      .reset     (reset),
      .clear     (1'b0),
      .push      (accept),
      .push_data (req_wr),
      .pop       (ack),
      .pop_data  (tag_head),
      .count     (tag_cnt)
   );

   resp_fifo #(
      .WIDTH (DATA_W + 1),
      .DEPTH (MAX_OUT)
   ) u_resp_fifo (
      .clk       (clk),
      .reset     (reset),
      .clear     (flush),
      .push      (resp_push),
      .push_data ({tag_head, bus_rdata}),
      .pop       (resp_pop),
      .pop_data  (resp_head),
      .count     (fifo_cnt)
   );

   a_data_ok_idle: assert property (@(posedge clk) disable iff (reset)
      !(bus_data_ok && (inflight == '0)));

   a_tag_track: assert property (@(posedge clk) disable iff (reset)
      tag_cnt == inflight);

endmodule

// File: tb/tb_sram_like_bridge.sv
// Self-checking bench for sram_like_bridge: directed scenarios followed by a
// randomized run, all compared against a transaction-level queue model.
module tb_sram_like_bridge;
   import bridge_pkg::*;

   localparam int ADDR_W  = 32;
   localparam int DATA_W  = 32;
   localparam int MAX_OUT = 2;

   logic                clk = 1'b0;
   logic                reset;
   logic                req_valid, req_ready, req_wr;
   logic [1:0]          req_size;
   logic [DATA_W/8-1:0] req_wstrb;
   logic [ADDR_W-1:0]   req_addr;
   logic [DATA_W-1:0]   req_wdata;
   logic                resp_valid, resp_ready, resp_wr;
   logic [DATA_W-1:0]   resp_rdata;
   logic                flush;
   logic                bus_req, bus_wr;
   logic [1:0]          bus_size;
   logic [DATA_W/8-1:0] bus_wstrb;
   logic [ADDR_W-1:0]   bus_addr;
   logic [DATA_W-1:0]   bus_wdata;
   logic                bus_addr_ok, bus_data_ok;
   logic [DATA_W-1:0]   bus_rdata;

   sram_like_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
      .req_size(req_size), .req_wstrb(req_wstrb), .req_addr(req_addr),
      .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
      .resp_wr(resp_wr), .flush(flush),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size),
      .bus_wstrb(bus_wstrb), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata)
   );

   always #5 clk = ~clk;

   // Model: transactions awaiting data_ok, and responses waiting for the pipeline.
   typedef struct packed {logic wr; logic cancelled;} pend_t;
   typedef struct packed {logic wr; logic [DATA_W-1:0] data;} resp_t;
   pend_t pend_q[$];
   resp_t resp_q[$];

   int  vectors = 0;
   int  errors  = 0;
   logic acc_last;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_bus_req();
      return req_valid && !flush && !reset && ((pend_q.size() + resp_q.size()) < MAX_OUT);
   endfunction

   function automatic logic exp_resp_valid();
      return (resp_q.size() > 0) && !flush && !reset;
   endfunction

   task automatic check_outputs();
      logic rv;
      rv = exp_resp_valid();
      chk("bus_req", bus_req, exp_bus_req());
      chk("req_ready", req_ready, exp_bus_req() && bus_addr_ok);
      chk("resp_valid", resp_valid, rv);
      chk("bus_addr", bus_addr, req_addr);
      chk("bus_wstrb", bus_wstrb, req_wstrb);
      if (rv) begin
         chk("resp_rdata", resp_rdata, resp_q[0].data);
         chk("resp_wr", resp_wr, resp_q[0].wr);
      end
   endtask

   task automatic model_update();
      logic  acc;
      pend_t p;
      acc = exp_bus_req() && bus_addr_ok;
      if (exp_resp_valid() && resp_ready) void'(resp_q.pop_front());
      if (flush) resp_q.delete();
      if (bus_data_ok && pend_q.size() > 0) begin
         p = pend_q.pop_front();
         if (!p.cancelled && !flush) resp_q.push_back({p.wr, bus_rdata});
      end
      if (acc) pend_q.push_back({req_wr, 1'b0});
      if (flush) foreach (pend_q[i]) pend_q[i].cancelled = 1'b1;
      acc_last = acc;
   endtask

   task automatic tick();
      #1;
      check_outputs();
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic idle_inputs();
      req_valid = 1'b0; req_wr = 1'b0; req_size = SZ_WORD; req_wstrb = 4'hf;
      req_addr = '0; req_wdata = '0; resp_ready = 1'b0; flush = 1'b0;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = '0;
   endtask

   task automatic read_req(input logic [ADDR_W-1:0] addr);
      req_valid = 1'b1; req_wr = 1'b0; req_size = SZ_WORD; req_wstrb = 4'hf;
      req_addr = addr; bus_addr_ok = 1'b1;
   endtask

   task automatic drain();
      for (int i = 0; i < 30; i++) begin
         if (pend_q.size() == 0 && resp_q.size() == 0) break;
         req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b1;
         bus_data_ok = (pend_q.size() > 0);
         bus_rdata = $urandom;
         tick();
      end
      resp_ready = 1'b0; bus_data_ok = 1'b0;
      #1;
      chk("drain_idle", resp_valid, 1'b0);
   endtask

   initial begin
      idle_inputs();
      reset = 1'b1;
      acc_last = 1'b0;
      @(negedge clk);
      chk("rst_bus_req", bus_req, 1'b0);
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_resp_rdata", resp_rdata, 32'h0);
      chk("rst_resp_wr", resp_wr, 1'b0);
      reset = 1'b0;

      // Single read round trip.
      read_req(32'h1c00_0000);
      #1 chk("t1_accept", req_ready, 1'b1);
      tick();
      idle_inputs();
      tick();
      bus_data_ok = 1'b1; bus_rdata = 32'hdead_beef;
      tick();
      idle_inputs();
      #1;
      chk("t1_resp_valid", resp_valid, 1'b1);
      chk("t1_rdata", resp_rdata, 32'hdead_beef);
      chk("t1_resp_wr", resp_wr, 1'b0);
      resp_ready = 1'b1;
      tick();
      idle_inputs();

      // Back-pressure: credit exhausted by unconsumed responses.
      read_req(32'h100); tick();
      read_req(32'h104); bus_data_ok = 1'b1; bus_rdata = 32'h1111_0000; tick();
      read_req(32'h108); bus_data_ok = 1'b1; bus_rdata = 32'h2222_0000; tick();
      bus_data_ok = 1'b0;
      #1 chk("bp_stall", bus_req, 1'b0);
      tick();
      resp_ready = 1'b1;
      #1 chk("bp_pop_cycle_stall", bus_req, 1'b0);
      tick();
      resp_ready = 1'b0;
      #1 chk("bp_third_accept", req_ready, 1'b1);
      tick();
      idle_inputs();
      drain();

      // Flush with two in flight.
      read_req(32'h200); tick();
      read_req(32'h204); tick();
      idle_inputs(); flush = 1'b1; tick();
      flush = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hbad0_0001; tick();
      bus_rdata = 32'hbad0_0002; tick();
      bus_data_ok = 1'b0;
      #1 chk("fl2_no_resp", resp_valid, 1'b0);
      read_req(32'h208); tick();
      idle_inputs(); bus_data_ok = 1'b1; bus_rdata = 32'h600d_0001; tick();
      idle_inputs();
      #1 chk("fl2_new_data", resp_rdata, 32'h600d_0001);
      drain();

      // Flush with one buffered and one in flight.
      read_req(32'h300); tick();
      read_req(32'h304); bus_data_ok = 1'b1; bus_rdata = 32'haaaa_0001; tick();
      idle_inputs(); flush = 1'b1;
      #1 chk("fl1_valid_drop", resp_valid, 1'b0);
      tick();
      flush = 1'b0;
      #1 chk("fl1_fifo_empty", resp_valid, 1'b0);
      bus_data_ok = 1'b1; bus_rdata = 32'haaaa_0002; tick();
      bus_data_ok = 1'b0;
      #1 chk("fl1_dropped", resp_valid, 1'b0);
      drain();

      // Write then read keep their order and tags.
      req_valid = 1'b1; req_wr = 1'b1; req_wstrb = 4'b0011; req_size = SZ_HALF;
      req_addr = 32'h400; req_wdata = 32'h0000_beef; bus_addr_ok = 1'b1;
      #1 chk("wr_wstrb", bus_wstrb, 4'b0011);
      tick();
      read_req(32'h404); bus_data_ok = 1'b1; bus_rdata = 32'h0; tick();
      idle_inputs(); bus_data_ok = 1'b1; bus_rdata = 32'hcafe_f00d; tick();
      idle_inputs();
      #1 chk("wr_resp_wr", resp_wr, 1'b1);
      resp_ready = 1'b1; tick();
      #1 chk("rd_resp_wr", resp_wr, 1'b0);
      chk("rd_after_wr_data", resp_rdata, 32'hcafe_f00d);
      tick();
      idle_inputs();

      // Asynchronous reset between addr_ok and data_ok.
      read_req(32'h500); tick();
      read_req(32'h504);
      #2 reset = 1'b1;
      #1;
      chk("arst_bus_req", bus_req, 1'b0);
      chk("arst_req_ready", req_ready, 1'b0);
      chk("arst_resp_valid", resp_valid, 1'b0);
      chk("arst_resp_rdata", resp_rdata, 32'h0);
      pend_q.delete(); resp_q.delete();
      idle_inputs();
      @(negedge clk);
      reset = 1'b0;
      tick(); tick();

      // Randomized traffic against the queue model.
      acc_last = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (!req_valid || acc_last) begin
            req_valid = ($urandom_range(0, 3) != 0);
            req_wr    = 1'($urandom_range(0, 1));
            req_size  = 2'($urandom_range(0, 2));
            req_wstrb = 4'($urandom_range(0, 15));
            req_addr  = $urandom;
            req_wdata = $urandom;
         end
         bus_addr_ok = ($urandom_range(0, 3) != 0);
         bus_data_ok = (pend_q.size() > 0) && ($urandom_range(0, 1) == 1);
         bus_rdata   = $urandom;
         resp_ready  = ($urandom_range(0, 2) != 0);
         flush       = ($urandom_range(0, 15) == 0);
         tick();
      end
      idle_inputs();
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
